stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer_pkg.sv | 42 ++++
 rtl/stage_sequencer.sv | 159 +++++++++++++++
 tb/tb_stage_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_sequencer_pkg.sv
// Shared opcode and state definitions for the stage sequencer and the write stage.
package stage_sequencer_pkg;

    localparam int unsigned OPC_W   = 7;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned RET_W   = 32;

    typedef logic [OPC_W-1:0] opcode_t;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    localparam opcode_t OP_R = 7'b0110011;
    localparam opcode_t OP_I = 7'b0010011;
    localparam opcode_t OP_L = 7'b0000011;
    localparam opcode_t OP_S = 7'b0100011;
    localparam opcode_t OP_B = 7'b1100011;

    function automatic logic is_supported(input opcode_t op);
        case (op)
            OP_R, OP_I, OP_L, OP_S, OP_B: is_supported = 1'b1;
            default:                      is_supported = 1'b0;
        endcase
    endfunction

    function automatic logic is_mem_op(input opcode_t op);
        is_mem_op = (op == OP_L) || (op == OP_S);
    endfunction

    // Types whose result is captured into the register file in WB.
    function automatic logic writes_rd(input opcode_t op);
        writes_rd = (op == OP_R) || (op == OP_I) || (op == OP_L);
    endfunction

endpackage

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: steps FETCH/DECODE/EXEC/MEM/WB with a
// memory-ack timeout and sticky fault flags; every output comes from a flop.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run_i,
    input  logic [31:0]          ir_i,
    input  logic                 mem_ack_i,
    output logic                 fetch_en_o,
    output logic                 decode_en_o,
    output logic                 exec_en_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic                 wd_q_readin_o,
    output logic                 pc_en_o,
    output logic                 illegal_o,
    output logic                 timeout_o,
    output logic [STATE_W-1:0]   state_o,
    output logic [RET_W-1:0]     retired_o
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_e             state_q, state_d;
    opcode_t            opcode_q, opcode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;
    logic [RET_W-1:0]   retired_q, retired_d;
    logic               fetch_en_q, fetch_en_d;
    logic               decode_en_q, decode_en_d;
    logic               exec_en_q, exec_en_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic               wd_q_readin_q, wd_q_readin_d;
    logic               pc_en_q, pc_en_d;

    // Only the opcode field steers sequencing.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_i[31:OPC_W];

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        cnt_d     = cnt_q;
        cnt_inc   = cnt_q + CNT_W'(1);
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        retired_d = retired_q;

        case (state_q)
            ST_IDLE: begin
                if (run_i) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                opcode_d = ir_i[OPC_W-1:0];
                if (is_supported(ir_i[OPC_W-1:0])) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end
            end
            ST_EXEC: begin
                if (is_mem_op(opcode_q)) begin
                    state_d = ST_MEM;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                // An ack on the expiry edge still completes the access.
                if (mem_ack_i) begin
                    state_d = ST_WB;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(MEM_TIMEOUT)) begin
                        state_d   = ST_HALT;
                        timeout_d = 1'b1;
                    end
                end
            end
            ST_WB: begin
                retired_d = retired_q + RET_W'(1);
                state_d   = run_i ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase

        fetch_en_d    = (state_d == ST_FETCH);
        decode_en_d   = (state_d == ST_DECODE);
        exec_en_d     = (state_d == ST_EXEC);
        mem_req_d     = (state_d == ST_MEM);
        mem_we_d      = (state_d == ST_MEM) && (opcode_d == OP_S);
        wd_q_readin_d = (state_d == ST_WB) && writes_rd(opcode_d);
        pc_en_d       = (state_d == ST_WB);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            opcode_q      <= '0;
            cnt_q         <= '0;
            illegal_q     <= 1'b0;
            timeout_q     <= 1'b0;
            retired_q     <= '0;
            fetch_en_q    <= 1'b0;
            decode_en_q   <= 1'b0;
            exec_en_q     <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            wd_q_readin_q <= 1'b0;
            pc_en_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            cnt_q         <= cnt_d;
            illegal_q     <= illegal_d;
            timeout_q     <= timeout_d;
            retired_q     <= retired_d;
            fetch_en_q    <= fetch_en_d;
            decode_en_q   <= decode_en_d;
            exec_en_q     <= exec_en_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            wd_q_readin_q <= wd_q_readin_d;
            pc_en_q       <= pc_en_d;
        end
    end

    assign fetch_en_o    = fetch_en_q;
    assign decode_en_o   = decode_en_q;
    assign exec_en_o     = exec_en_q;
    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign wd_q_readin_o = wd_q_readin_q;
    assign pc_en_o       = pc_en_q;
    assign illegal_o     = illegal_q;
    assign timeout_o     = timeout_q;
    assign state_o       = state_q;
    assign retired_o     = retired_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed scenarios plus random instruction streams
// compared cycle by cycle against a trace predicted from the sequencing rules.
module tb_stage_sequencer;

    localparam int MEM_TIMEOUT = 15;

    typedef struct packed {
        logic [2:0] st;
        logic fe, de, ex, rq, we, wd, pc, il, to;
        logic ak;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run_i = 1'b0;
    logic [31:0] ir_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        fetch_en_o, decode_en_o, exec_en_o, mem_req_o, mem_we_o;
    logic        wd_q_readin_o, pc_en_o, illegal_o, timeout_o;
    logic [2:0]  state_o;
    logic [31:0] retired_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_ret = '0;
    bit          at_idle = 1'b1;
    bit          halted = 1'b0;
    exp_t        exp_q[$];

    stage_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .run_i(run_i), .ir_i(ir_i), .mem_ack_i(mem_ack_i),
        .fetch_en_o(fetch_en_o), .decode_en_o(decode_en_o), .exec_en_o(exec_en_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .wd_q_readin_o(wd_q_readin_o),
        .pc_en_o(pc_en_o), .illegal_o(illegal_o), .timeout_o(timeout_o),
        .state_o(state_o), .retired_o(retired_o)
    );

    always #5 clk = ~clk;

    function automatic exp_t observe();
        observe = exp_t'({state_o, fetch_en_o, decode_en_o, exec_en_o, mem_req_o,
                          mem_we_o, wd_q_readin_o, pc_en_o, illegal_o, timeout_o, 1'b0});
    endfunction

    // Expected per-cycle trace of one instruction from FETCH onward; d = MEM cycle
    // index on which ack arrives (negative = never).
    task automatic build(input logic [31:0] ir, input int d);
        exp_t e;
        logic [6:0] op;
        bit ok, is_ls, is_s, wr;
        op    = ir[6:0];
        ok    = (op == 7'h33) || (op == 7'h13) || (op == 7'h03) || (op == 7'h23) || (op == 7'h63);
        is_ls = (op == 7'h03) || (op == 7'h23);
        is_s  = (op == 7'h23);
        wr    = (op == 7'h33) || (op == 7'h13) || (op == 7'h03);
        exp_q.delete();
        e = '0; e.st = 3'd1; e.fe = 1'b1; exp_q.push_back(e);
        e = '0; e.st = 3'd2; e.de = 1'b1; exp_q.push_back(e);
        if (!ok) begin
            for (int i = 0; i < 4; i++) begin
                e = '0; e.st = 3'd6; e.il = 1'b1; exp_q.push_back(e);
            end
            return;
        end
        e = '0; e.st = 3'd3; e.ex = 1'b1; exp_q.push_back(e);
        if (is_ls) begin
            for (int k = 0; k < MEM_TIMEOUT; k++) begin
                e = '0; e.st = 3'd4; e.rq = 1'b1; e.we = is_s; e.ak = (k == d);
                exp_q.push_back(e);
                if (k == d) break;
            end
            if (d < 0 || d >= MEM_TIMEOUT) begin
                for (int i = 0; i < 4; i++) begin
                    e = '0; e.st = 3'd6; e.to = 1'b1; exp_q.push_back(e);
                end
                return;
            end
        end
        e = '0; e.st = 3'd5; e.wd = wr; e.pc = 1'b1; exp_q.push_back(e);
    endtask

    // Runs one instruction through the DUT, comparing every cycle to the trace.
    task automatic run_instr(input logic [31:0] ir, input int d, input bit run_next);
        exp_t o, ex;
        build(ir, d);
        ir_i = ir;
        if (at_idle) begin
            @(negedge clk);
            checks++;
            if (state_o !== 3'd0 || retired_o !== model_ret) begin
                errors++;
                $display("FAIL idle_before_run state=%0d retired=%h, expected state=0 retired=%h",
                         state_o, retired_o, model_ret);
            end
            run_i = 1'b1;
            mem_ack_i = 1'($urandom);
        end
        foreach (exp_q[i]) begin
            @(negedge clk);
            o = observe();
            ex = exp_q[i];
            ex.ak = 1'b0;
            checks++;
            if (o !== ex) begin
                errors++;
                $display("FAIL trace ir=%h cycle=%0d got {st,fe,de,ex,rq,we,wd,pc,il,to}=%b expected %b",
                         ir, i, o[12:1], ex[12:1]);
            end
            checks++;
            if (retired_o !== model_ret) begin
                errors++;
                $display("FAIL retired ir=%h cycle=%0d got %h expected %h", ir, i, retired_o, model_ret);
            end
            run_i     = (exp_q[i].st == 3'd5) ? run_next : 1'($urandom);
            mem_ack_i = exp_q[i].ak ? 1'b1 : ((exp_q[i].st == 3'd4) ? 1'b0 : 1'($urandom));
            if (exp_q[i].st >= 3'd3) ir_i = $urandom;
        end
        halted = (exp_q[exp_q.size()-1].st == 3'd6);
        if (!halted) begin
            model_ret = model_ret + 32'd1;
            at_idle = !run_next;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        run_i = 1'b1;
        mem_ack_i = 1'b1;
        @(negedge clk);
        checks++;
        if (observe() !== exp_t'(0) || retired_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_state got %b retired=%h expected all zero", observe(), retired_o);
        end
        reset = 1'b1;
        run_i = 1'b0;
        mem_ack_i = 1'b0;
        model_ret = '0;
        at_idle = 1'b1;
        halted = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (state_o !== 3'd0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold state=%0d mem_req=%b expected 0/0", state_o, mem_req_o);
        end
    endtask

    task automatic test_rtype();
        run_instr(32'h00B5_0533, 0, 1'b0);
        @(negedge clk);
        checks++;
        if (state_o !== 3'd0 || retired_o !== 32'd1) begin
            errors++;
            $display("FAIL rtype_done state=%0d retired=%h expected 0 and 1", state_o, retired_o);
        end
    endtask

    task automatic test_load();
        run_instr(32'h0000_A103, 3, 1'b0);
    endtask

    task automatic test_store_timeout();
        run_instr(32'h0020_A023, -1, 1'b0);
        checks++;
        if (!halted || timeout_o !== 1'b1 || pc_en_o !== 1'b0) begin
            errors++;
            $display("FAIL store_timeout halted=%b timeout=%b pc_en=%b expected 1/1/0",
                     halted, timeout_o, pc_en_o);
        end
        apply_reset();
    endtask

    task automatic test_ack_on_expiry();
        run_instr(32'h0000_A103, MEM_TIMEOUT - 1, 1'b0);
        run_instr(32'h0020_A023, 0, 1'b0);
    endtask

    task automatic test_illegal();
        run_instr(32'h0000_007F, 0, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (state_o !== 3'd6 || illegal_o !== 1'b1 || fetch_en_o !== 1'b0) begin
            errors++;
            $display("FAIL illegal_sticky state=%0d illegal=%b fetch=%b expected 6/1/0",
                     state_o, illegal_o, fetch_en_o);
        end
        apply_reset();
    endtask

    task automatic test_branch_wrap();
        @(negedge clk);
        force dut.retired_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retired_q;
        model_ret = 32'hFFFF_FFFF;
        run_instr(32'h0000_0063, 0, 1'b0);
        @(negedge clk);
        checks++;
        if (retired_o !== 32'd0) begin
            errors++;
            $display("FAIL retired_wrap got %h expected 00000000", retired_o);
        end
    endtask

    task automatic test_back_to_back();
        run_instr(32'h00B5_0533, 0, 1'b1);
        run_instr(32'h0010_0093, 0, 1'b1);
        run_instr(32'h0000_A103, 0, 1'b1);
        run_instr(32'h0000_0063, 0, 1'b0);
    endtask

    task automatic test_reset_in_mem();
        run_instr(32'h00B5_0533, 0, 1'b0);
        @(negedge clk);
        ir_i = 32'h0020_A023;
        run_i = 1'b1;
        repeat (4) @(negedge clk);
        run_i = 1'b0;
        checks++;
        if (state_o !== 3'd4 || mem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL mem_before_reset state=%0d mem_req=%b expected 4/1", state_o, mem_req_o);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (state_o !== 3'd0 || mem_req_o !== 1'b0 || retired_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_in_mem state=%0d mem_req=%b retired=%h expected 0/0/0",
                     state_o, mem_req_o, retired_o);
        end
        reset = 1'b1;
        mem_ack_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (state_o !== 3'd0 || mem_req_o !== 1'b0 || pc_en_o !== 1'b0) begin
            errors++;
            $display("FAIL late_ack state=%0d mem_req=%b pc_en=%b expected 0/0/0",
                     state_o, mem_req_o, pc_en_o);
        end
        mem_ack_i = 1'b0;
        model_ret = '0;
        at_idle = 1'b1;
    endtask

    task automatic test_random();
        logic [6:0]  ops [5];
        logic [31:0] ir;
        int          d, kind;
        bit          rn;
        ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23; ops[4] = 7'h63;
        for (int n = 0; n < 60; n++) begin
            ir = $urandom;
            kind = int'($urandom_range(0, 19));
            if (kind == 0) begin
                while (ir[6:0] == 7'h33 || ir[6:0] == 7'h13 || ir[6:0] == 7'h03 ||
                       ir[6:0] == 7'h23 || ir[6:0] == 7'h63) ir = $urandom;
            end else begin
                ir[6:0] = ops[kind % 5];
            end
            case ($urandom_range(0, 9))
                0:       d = -1;
                1:       d = MEM_TIMEOUT - 1;
                default: d = int'($urandom_range(0, 6));
            endcase
            rn = (n == 59) ? 1'b0 : 1'($urandom);
            run_instr(ir, d, rn);
            if (halted) apply_reset();
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load();
        test_store_timeout();
        test_ack_on_expiry();
        test_illegal();
        test_branch_wrap();
        test_back_to_back();
        test_reset_in_mem();
        test_random();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
